// File: rtl/bus_pkg.sv
// Shared bus types: serial frame layout, command codes, frame parity and arbiter state encoding.
package bus_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE          = 2'd0,
        CMD_READ           = 2'd1,
        CMD_SPLIT_START    = 2'd2,
        CMD_SPLIT_CONTINUE = 2'd3
    } cmd_e;

    typedef struct packed {
        logic        start;
        cmd_e        cmd;
        logic [13:0] addr;
        logic [7:0]  data;
        logic        parity;
        logic        stop;
    } serial_frame_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_GAP    = 2'd3
    } arb_state_e;

    // Even parity over the payload: the bit makes cmd+addr+data+parity carry an even count of ones.
    function automatic logic calc_parity(input cmd_e cmd, input logic [13:0] addr, input logic [7:0] data);
        return ^{cmd, addr, data};
    endfunction

endpackage

// File: rtl/ser_tx_arbiter_if.sv
// Request, serializer and completion signals of ser_tx_arbiter; slave = arbiter, master = its environment.
interface ser_tx_arbiter_if
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    cmd_e [NUM_REQ-1:0]       req_cmd_i;
    logic [NUM_REQ-1:0][13:0] req_addr_i;
    logic [NUM_REQ-1:0][7:0]  req_data_i;
    logic                     ser_start_o;
    serial_frame_t            ser_frame_o;
    logic                     ser_busy_i;
    logic                     ser_done_i;
    logic                     cpl_valid_o;
    logic [IDW-1:0]           cpl_id_o;
    logic                     cpl_err_o;
    logic                     busy_o;

    modport slave (
        input  req_valid_i, req_cmd_i, req_addr_i, req_data_i, ser_busy_i, ser_done_i,
        output req_ready_o, ser_start_o, ser_frame_o, cpl_valid_o, cpl_id_o, cpl_err_o, busy_o
    );

    modport master (
        output req_valid_i, req_cmd_i, req_addr_i, req_data_i, ser_busy_i, ser_done_i,
        input  req_ready_o, ser_start_o, ser_frame_o, cpl_valid_o, cpl_id_o, cpl_err_o, busy_o
    );

endinterface

// File: rtl/ser_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_grant, wrapping; pointer lives in the parent.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_grant_i,
    output logic [IDW-1:0] grant_o,
    output logic           grant_valid_o
);

    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        grant_o       = last_grant_i;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IDW'((int'(last_grant_i) + i) % N);
            if (req_i[idx]) begin
                grant_o       = idx;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_tx_arbiter.sv
// Round-robin share of one serializer; request-to-start 1 clk, holds off while ser_busy_i, GAP idle after each frame.
// SER_ARB_TIMEOUT_EN adds a WAIT watchdog that completes with cpl_err_o after TIMEOUT_CYCLES.
module ser_tx_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ser_tx_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int GW  = $clog2(GAP_CYCLES + 2);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("ser_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (GAP_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
        $error("ser_tx_arbiter: GAP_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     last_q, last_d;
    serial_frame_t      frame_q, frame_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               cpl_valid_q, cpl_valid_d;
    logic [IDW-1:0]     cpl_id_q, cpl_id_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [IDW-1:0]     arb_g;
    logic               arb_vld;

`ifdef SER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cpl_err_q, cpl_err_d;
`endif

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .req_i         (bus.req_valid_i),
        .last_grant_i  (last_q),
        .grant_o       (arb_g),
        .grant_valid_o (arb_vld)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        frame_d     = frame_q;
        start_d     = 1'b0;
        ready_d     = '0;
        cpl_valid_d = 1'b0;
        cpl_id_d    = cpl_id_q;
        gap_d       = gap_q;
`ifdef SER_ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        cpl_err_d   = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (arb_vld && !bus.ser_busy_i) begin
                    grant_d        = arb_g;
                    frame_d.start  = 1'b1;
                    frame_d.cmd    = bus.req_cmd_i[arb_g];
                    frame_d.addr   = bus.req_addr_i[arb_g];
                    frame_d.data   = bus.req_data_i[arb_g];
                    frame_d.parity = calc_parity(bus.req_cmd_i[arb_g], bus.req_addr_i[arb_g],
                                                 bus.req_data_i[arb_g]);
                    frame_d.stop   = 1'b1;
                    start_d        = 1'b1;
                    ready_d        = NUM_REQ'(1) << arb_g;
                    state_d        = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                last_d  = grant_q;
                state_d = ARB_WAIT;
`ifdef SER_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ARB_WAIT: begin
                if (bus.ser_done_i) begin
                    cpl_valid_d = 1'b1;
                    cpl_id_d    = grant_q;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GW'(GAP_CYCLES);
                        state_d = ARB_GAP;
                    end else begin
                        state_d = ARB_IDLE;
                    end
`ifdef SER_ARB_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    cpl_valid_d = 1'b1;
                    cpl_err_d   = 1'b1;
                    cpl_id_d    = grant_q;
                    gap_d       = GW'(GAP_CYCLES);
                    state_d     = ARB_GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            ARB_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // last_q starts at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            last_q      <= IDW'(NUM_REQ - 1);
            frame_q     <= '0;
            start_q     <= 1'b0;
            ready_q     <= '0;
            cpl_valid_q <= 1'b0;
            cpl_id_q    <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            frame_q     <= frame_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_id_q    <= cpl_id_d;
            gap_q       <= gap_d;
        end
    end

`ifdef SER_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q     <= '0;
            cpl_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            cpl_err_q <= cpl_err_d;
        end
    end
    assign bus.cpl_err_o = cpl_err_q;
`else
    assign bus.cpl_err_o = 1'b0;
`endif

    assign bus.req_ready_o = ready_q;
    assign bus.ser_start_o = start_q;
    assign bus.ser_frame_o = frame_q;
    assign bus.cpl_valid_o = cpl_valid_q;
    assign bus.cpl_id_o    = cpl_id_q;
    assign bus.busy_o      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Directed bench for ser_tx_arbiter: reset, single frames, busy hold-off, reset mid-frame, fairness, WAIT watchdog.
module tb_ser_tx_arbiter;
    import bus_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cyc = 0;
    int   seen;
    logic [3:0]  exp_rdy;
    logic [26:0] exp_w;
    logic [26:0] exp_r;

    ser_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    ser_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (bus.ser_start_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 64'(bus.ser_start_o), 64'd1);
    endtask

    initial begin
        // {start, cmd, addr, data, parity, stop}; parities counted by hand (10 ones -> 0, 3 ones -> 1)
        exp_w = {1'b1, 2'b00, 14'h1234, 8'hAB, 1'b0, 1'b1};
        exp_r = {1'b1, 2'b01, 14'h0001, 8'h01, 1'b1, 1'b1};

        rst = 1'b1;
        bus.req_valid_i = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.req_cmd_i[i]  = CMD_WRITE;
            bus.req_addr_i[i] = '0;
            bus.req_data_i[i] = '0;
        end
        bus.ser_busy_i = 1'b0;
        bus.ser_done_i = 1'b0;
        tick();
        tick();
        check("rst_start", 64'(bus.ser_start_o), 64'd0);
        check("rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_cpl", 64'(bus.cpl_valid_o), 64'd0);
        check("rst_err", 64'(bus.cpl_err_o), 64'd0);
        check("rst_frame", 64'(bus.ser_frame_o), 64'd0);

        bus.req_valid_i = 4'b0000;
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(bus.busy_o), 64'd0);

        // Single request from requester 2
        bus.req_cmd_i[2]  = CMD_WRITE;
        bus.req_addr_i[2] = 14'h1234;
        bus.req_data_i[2] = 8'hAB;
        bus.req_valid_i   = 4'b0100;
        tick();
        check("t2_start", 64'(bus.ser_start_o), 64'd1);
        check("t2_ready", 64'(bus.req_ready_o), 64'b0100);
        check("t2_frame", 64'(bus.ser_frame_o), 64'(exp_w));
        check("t2_busy", 64'(bus.busy_o), 64'd1);
        bus.req_valid_i = 4'b0000;
        tick();
        check("t2_start_pulse", 64'(bus.ser_start_o), 64'd0);
        check("t2_ready_pulse", 64'(bus.req_ready_o), 64'd0);
        tick();
        tick();
        check("t2_frame_held", 64'(bus.ser_frame_o), 64'(exp_w));
        check("t2_no_early_cpl", 64'(bus.cpl_valid_o), 64'd0);
        bus.ser_done_i = 1'b1;
        tick();
        bus.ser_done_i = 1'b0;
        check("t2_cpl_valid", 64'(bus.cpl_valid_o), 64'd1);
        check("t2_cpl_id", 64'(bus.cpl_id_o), 64'd2);
        check("t2_cpl_err", 64'(bus.cpl_err_o), 64'd0);
        tick();
        check("t2_cpl_pulse", 64'(bus.cpl_valid_o), 64'd0);
        check("t2_gap_busy", 64'(bus.busy_o), 64'd1);
        tick();
        tick();
        check("t2_back_idle", 64'(bus.busy_o), 64'd0);

        // Done outside WAIT is ignored
        bus.ser_done_i = 1'b1;
        tick();
        bus.ser_done_i = 1'b0;
        check("stray_done_cpl", 64'(bus.cpl_valid_o), 64'd0);
        check("stray_done_busy", 64'(bus.busy_o), 64'd0);

        // Busy hold-off with requester 1
        bus.ser_busy_i    = 1'b1;
        bus.req_cmd_i[1]  = CMD_READ;
        bus.req_addr_i[1] = 14'h0001;
        bus.req_data_i[1] = 8'h01;
        bus.req_valid_i   = 4'b0010;
        seen = 0;
        repeat (3) begin
            tick();
            if (bus.ser_start_o !== 1'b0 || bus.req_ready_o !== 4'b0000) seen++;
        end
        check("t4_held_off", 64'(seen), 64'd0);
        bus.ser_busy_i = 1'b0;
        tick();
        check("t4_start", 64'(bus.ser_start_o), 64'd1);
        check("t4_ready", 64'(bus.req_ready_o), 64'b0010);
        check("t4_frame", 64'(bus.ser_frame_o), 64'(exp_r));
        bus.req_valid_i = 4'b0000;
        tick();
        bus.ser_done_i = 1'b1;
        tick();
        bus.ser_done_i = 1'b0;
        check("t4_cpl_id", 64'(bus.cpl_id_o), 64'd1);
        check("t4_cpl_valid", 64'(bus.cpl_valid_o), 64'd1);
        tick();
        tick();
        check("t4_back_idle", 64'(bus.busy_o), 64'd0);

        // Reset in the middle of a frame from requester 3
        bus.req_cmd_i[3]  = CMD_SPLIT_START;
        bus.req_addr_i[3] = 14'h3FFF;
        bus.req_data_i[3] = 8'hFF;
        bus.req_valid_i   = 4'b1000;
        tick();
        check("t5_ready", 64'(bus.req_ready_o), 64'b1000);
        bus.req_valid_i = 4'b0000;
        tick();
        tick();
        check("t5_in_wait", 64'(bus.busy_o), 64'd1);
        bus.req_valid_i = 4'b1111;
        rst = 1'b1;
        #1;
        check("t5_rst_start", 64'(bus.ser_start_o), 64'd0);
        check("t5_rst_ready", 64'(bus.req_ready_o), 64'd0);
        check("t5_rst_busy", 64'(bus.busy_o), 64'd0);
        check("t5_rst_cpl", 64'(bus.cpl_valid_o), 64'd0);
        check("t5_rst_frame", 64'(bus.ser_frame_o), 64'd0);
        tick();
        rst = 1'b0;

        // Fairness with all requesters valid: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            wait_start("rr");
            exp_rdy = 4'b0001 << (k % 4);
            check("rr_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
            if (k > 0) check("rr_gap_ok", 64'((cyc - done_cyc - 1) >= 2), 64'd1);
            if (k < 4) begin
                tick();
                tick();
                bus.ser_done_i = 1'b1;
                done_cyc = cyc;
                tick();
                bus.ser_done_i = 1'b0;
                check("rr_cpl_valid", 64'(bus.cpl_valid_o), 64'd1);
                check("rr_cpl_id", 64'(bus.cpl_id_o), 64'(k % 4));
            end
        end

        // The fifth frame (requester 0) never receives done
        bus.req_valid_i = 4'b0000;
        seen = 0;
        repeat (16) begin
            tick();
            if (bus.cpl_valid_o !== 1'b0) seen++;
        end
        check("tmo_no_early_cpl", 64'(seen), 64'd0);
        tick();
`ifdef SER_ARB_TIMEOUT_EN
        check("tmo_cpl_valid", 64'(bus.cpl_valid_o), 64'd1);
        check("tmo_cpl_err", 64'(bus.cpl_err_o), 64'd1);
        check("tmo_cpl_id", 64'(bus.cpl_id_o), 64'd0);
        tick();
        check("tmo_cpl_pulse", 64'(bus.cpl_valid_o), 64'd0);
        check("tmo_gap_busy", 64'(bus.busy_o), 64'd1);
        tick();
        tick();
        check("tmo_back_idle", 64'(bus.busy_o), 64'd0);
`else
        check("wait_no_cpl", 64'(bus.cpl_valid_o), 64'd0);
        check("wait_no_err", 64'(bus.cpl_err_o), 64'd0);
        check("wait_busy", 64'(bus.busy_o), 64'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.cpl_valid_o !== 1'b0 || bus.busy_o !== 1'b1) seen++;
        end
        check("wait_forever", 64'(seen), 64'd0);
        bus.ser_done_i = 1'b1;
        tick();
        bus.ser_done_i = 1'b0;
        check("late_cpl_valid", 64'(bus.cpl_valid_o), 64'd1);
        check("late_cpl_err", 64'(bus.cpl_err_o), 64'd0);
        check("late_cpl_id", 64'(bus.cpl_id_o), 64'd0);
        tick();
        tick();
        check("late_back_idle", 64'(bus.busy_o), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
